// File: rtl/im_loader_pkg.sv
// rtl/im_loader_pkg.sv - shared types and constants for the instruction-memory program loader
package im_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } loader_state_e;

  localparam int BYTES_PER_WORD = 2;

  // Word count header arrives most-significant byte first.
  localparam bit HEADER_MSB_FIRST = 1'b1;

  function automatic logic is_byte_wait(input loader_state_e s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
           (s == S_DATA_LO) || (s == S_CHECK);
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// rtl/loader_timeout.sv - idle-cycle watchdog between accepted bytes
module loader_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] r_count;

  assign o_expired = i_enable && !i_clear && (r_count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_clear || o_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/im_program_loader.sv
// rtl/im_program_loader.sv - byte-stream program loader driving the IM write port and CPU reset/start
module im_program_loader
  import im_loader_pkg::*;
#(
  parameter int ADDR_WIDTH       = 10,
  parameter int DATA_WIDTH       = 16,
  parameter int TIMEOUT_CYCLES   = 1024,
  parameter int CPU_RESET_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load_req,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  output logic                  o_im_en_write,
  output logic [ADDR_WIDTH-1:0] o_im_address,
  output logic [DATA_WIDTH-1:0] o_im_data_in,
  output logic                  o_cpu_reset,
  output logic                  o_cpu_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_words_loaded
);

  localparam int IM_DEPTH = 1 << ADDR_WIDTH;
  localparam int BYTE_W   = DATA_WIDTH / BYTES_PER_WORD;
  localparam int RW       = (CPU_RESET_CYCLES > 1) ? $clog2(CPU_RESET_CYCLES) : 1;

  loader_state_e       r_state;
  loader_state_e       w_next;
  logic [7:0]          r_len_first;
  logic [15:0]         r_len;
  logic [BYTE_W-1:0]   r_data_hi;
  logic [7:0]          r_checksum;
  logic [RW-1:0]       r_rel_cnt;

  logic                w_xfer;
  logic                w_start;
  logic                w_wait;
  logic                w_timeout;
  logic [15:0]         w_len_full;
  logic                w_len_bad;
  logic [ADDR_WIDTH:0] w_count_inc;
  logic                w_last_word;

  assign w_xfer      = i_rx_valid && o_rx_ready;
  assign w_wait      = is_byte_wait(r_state);
  assign w_start     = i_load_req &&
                       ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_len_full  = HEADER_MSB_FIRST ? {r_len_first, i_rx_data} : {i_rx_data, r_len_first};
  assign w_len_bad   = (w_len_full == 16'd0) || (32'(w_len_full) > IM_DEPTH);
  assign w_count_inc = o_words_loaded + 1'b1;
  assign w_last_word = (32'(w_count_inc) == 32'(r_len));

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_xfer || w_start),
    .i_enable  (w_wait),
    .o_expired (w_timeout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (i_load_req) w_next = S_LEN_HI;
      S_LEN_HI:  if (w_xfer) w_next = S_LEN_LO;
      S_LEN_LO:  if (w_xfer) w_next = w_len_bad ? S_ERROR : S_DATA_HI;
      S_DATA_HI: if (w_xfer) w_next = S_DATA_LO;
      S_DATA_LO: if (w_xfer) w_next = S_WRITE;
      S_WRITE:   w_next = w_last_word ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (w_xfer) w_next = (i_rx_data == r_checksum) ? S_RELEASE : S_ERROR;
      S_RELEASE: if (r_rel_cnt == RW'(CPU_RESET_CYCLES - 1)) w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_ERROR;
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_len_first    <= '0;
      r_len          <= '0;
      r_data_hi      <= '0;
      r_checksum     <= '0;
      r_rel_cnt      <= '0;
      o_rx_ready     <= 1'b0;
      o_im_en_write  <= 1'b0;
      o_im_address   <= '0;
      o_im_data_in   <= '0;
      o_cpu_reset    <= 1'b1;
      o_cpu_start    <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_words_loaded <= '0;
    end else begin
      r_state       <= w_next;
      o_rx_ready    <= is_byte_wait(w_next);
      o_im_en_write <= (w_next == S_WRITE);
      o_busy        <= (w_next != S_IDLE) && (w_next != S_DONE) && (w_next != S_ERROR);
      o_cpu_reset   <= (w_next != S_DONE);
      o_cpu_start   <= (w_next == S_RELEASE) || (w_next == S_DONE);
      o_done        <= (w_next == S_DONE);
      o_error       <= (w_next == S_ERROR);
      r_rel_cnt     <= (r_state == S_RELEASE) ? r_rel_cnt + 1'b1 : '0;

      if (w_start) begin
        o_words_loaded <= '0;
        r_checksum     <= '0;
      end else if (r_state == S_WRITE) begin
        o_words_loaded <= w_count_inc;
      end

      if (w_xfer) begin
        case (r_state)
          S_LEN_HI: r_len_first <= i_rx_data;
          S_LEN_LO: r_len       <= w_len_full;
          S_DATA_HI: begin
            r_data_hi  <= BYTE_W'(i_rx_data);
            r_checksum <= r_checksum ^ i_rx_data;
          end
          S_DATA_LO: begin
            r_checksum   <= r_checksum ^ i_rx_data;
            o_im_address <= o_words_loaded[ADDR_WIDTH-1:0];
            o_im_data_in <= DATA_WIDTH'({r_data_hi, i_rx_data});
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_program_loader.sv
// tb/tb_im_program_loader.sv - directed self-checking bench for im_program_loader
module tb_im_program_loader;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int TO = 1024;

  logic          clk      = 1'b0;
  logic          reset    = 1'b1;
  logic          load_req = 1'b0;
  logic [7:0]    rx_data  = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic          im_en_write;
  logic [AW-1:0] im_address;
  logic [DW-1:0] im_data_in;
  logic          cpu_reset;
  logic          cpu_start;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  im_program_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CPU_RESET_CYCLES(2)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_load_req(load_req),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .o_im_en_write(im_en_write), .o_im_address(im_address), .o_im_data_in(im_data_in),
    .o_cpu_reset(cpu_reset), .o_cpu_start(cpu_start), .o_busy(busy),
    .o_done(done), .o_error(error), .o_words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          wr_cnt = 0;
  int          start_cnt = 0;
  int          long_pulse_cnt = 0;
  int          ready_in_write_cnt = 0;
  logic        prev_en = 1'b0;
  logic [AW-1:0] wr_addr [0:2047];
  logic [DW-1:0] wr_data [0:2047];

  always @(negedge clk) begin
    if (im_en_write) begin
      wr_addr[wr_cnt % 2048] = im_address;
      wr_data[wr_cnt % 2048] = im_data_in;
      wr_cnt++;
    end
    if (im_en_write && prev_en) long_pulse_cnt++;
    if (im_en_write && rx_ready) ready_in_write_cnt++;
    if (cpu_start) start_cnt++;
    prev_en = im_en_write;
  end

  logic [7:0] norm_s [0:8] = '{8'h00, 8'h03, 8'h40, 8'h04, 8'h70, 8'h00, 8'h40, 8'h02, 8'h76};
  int         gaps_t [0:8] = '{2, 0, 5, 1, 0, 3, 0, 4, 5};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rx_ready_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic send_normal(input logic [7:0] last, input bit use_gaps);
    for (int i = 0; i < 9; i++)
      send_byte((i == 8) ? last : norm_s[i], use_gaps ? gaps_t[i] : 0);
    rx_valid = 1'b0;
  endtask

  task automatic check_normal_writes(input string tag, input int base);
    check({tag, "_wr_count"}, 32'(wr_cnt - base), 32'd3);
    check({tag, "_wr0"}, {wr_addr[base % 2048], wr_data[base % 2048]}, {10'd0, 16'h4004});
    check({tag, "_wr1"}, {wr_addr[(base + 1) % 2048], wr_data[(base + 1) % 2048]}, {10'd1, 16'h7000});
    check({tag, "_wr2"}, {wr_addr[(base + 2) % 2048], wr_data[(base + 2) % 2048]}, {10'd2, 16'h4002});
  endtask

  task automatic check_release_done(input string tag);
    check({tag, "_rel1"}, {cpu_reset, cpu_start, busy, done}, 4'b1110);
    @(negedge clk);
    check({tag, "_rel2"}, {cpu_reset, cpu_start, busy, done}, 4'b1110);
    @(negedge clk);
    check({tag, "_done"}, {cpu_reset, cpu_start, busy, done, error}, 5'b01010);
    check({tag, "_words"}, 32'(words_loaded), 32'd3);
  endtask

  initial begin
    int base;
    int sbase;
    int bad;
    logic [7:0]  csum;
    logic [15:0] w;

    // Reset state
    @(negedge clk);
    check("reset_ctl", {rx_ready, im_en_write, cpu_reset, cpu_start, busy, done, error}, 7'b0010000);
    check("reset_data", {im_address, im_data_in, 5'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_hold", {cpu_reset, busy, rx_ready}, 3'b100);

    // Normal load, rx_valid held high
    base = wr_cnt;
    start_load();
    check("start_busy", {busy, rx_ready, cpu_reset, cpu_start}, 4'b1110);
    send_normal(8'h76, 1'b0);
    check_normal_writes("normal", base);
    check_release_done("normal");
    check("normal_pulse_len", 32'(long_pulse_cnt), 32'd0);

    // Bad checksum
    base = wr_cnt;
    start_load();
    sbase = start_cnt;
    check("restart_halt", {cpu_reset, cpu_start, done, busy}, 4'b1001);
    send_normal(8'h77, 1'b0);
    check_normal_writes("badck", base);
    check("badck_state", {error, done, cpu_start, cpu_reset, busy}, 5'b10010);
    check("badck_no_start", 32'(start_cnt - sbase), 32'd0);

    // Length errors
    base = wr_cnt;
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rx_valid = 1'b0;
    check("len0_err", {error, busy, rx_ready, cpu_reset}, 4'b1001);
    start_load();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    rx_valid = 1'b0;
    check("len401_err", {error, busy, rx_ready, cpu_reset}, 4'b1001);
    check("len_no_write", 32'(wr_cnt - base), 32'd0);

    // Full-depth load: N = 1024
    base = wr_cnt;
    csum = 8'h00;
    start_load();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    check("len400_ok", {error, busy, rx_ready}, 3'b011);
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i * 37 + 5);
      csum = csum ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], 0);
      send_byte(w[7:0], 0);
    end
    send_byte(csum, 0);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("full_done", {done, error, cpu_reset}, 3'b100);
    check("full_words", 32'(words_loaded), 32'd1024);
    check("full_wr_count", 32'(wr_cnt - base), 32'd1024);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      w = 16'(i * 37 + 5);
      if (wr_addr[(base + i) % 2048] !== AW'(i) || wr_data[(base + i) % 2048] !== w) bad++;
    end
    check("full_wr_content", 32'(bad), 32'd0);
    check("full_last_addr", 32'(im_address), 32'd1023);

    // Timeout after 00 01 40
    base = wr_cnt;
    start_load();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h40, 0);
    rx_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    check("timeout_edge", {busy, error, rx_ready}, 3'b101);
    @(negedge clk);
    check("timeout_err", {busy, error, rx_ready, cpu_reset}, 4'b0101);
    check("timeout_no_write", 32'(wr_cnt - base), 32'd0);

    // Handshake gaps
    base = wr_cnt;
    sbase = ready_in_write_cnt;
    start_load();
    send_normal(8'h76, 1'b1);
    check_normal_writes("gaps", base);
    check_release_done("gaps");
    check("gaps_ready_in_write", 32'(ready_in_write_cnt - sbase), 32'd0);

    // Abort mid-load, then reload with a stray load_req
    start_load();
    for (int i = 0; i < 7; i++) send_byte(norm_s[i], 0);
    rx_valid = 1'b0;
    check("abort_pre", {busy, 5'd0, words_loaded}, {1'b1, 5'd0, 11'd2});
    #2 reset = 1'b1;
    #1;
    check("abort_ctl", {rx_ready, im_en_write, cpu_reset, cpu_start, busy, done, error}, 7'b0010000);
    check("abort_data", {im_address, im_data_in, 5'd0, words_loaded}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    base = wr_cnt;
    start_load();
    for (int i = 0; i < 4; i++) send_byte(norm_s[i], 0);
    rx_valid = 1'b0;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    check("stray_req_ignored", {busy, 5'd0, words_loaded}, {1'b1, 5'd0, 11'd1});
    for (int i = 4; i < 9; i++) send_byte(norm_s[i], 0);
    rx_valid = 1'b0;
    check_normal_writes("reload", base);
    check_release_done("reload");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
